// File: rtl/floor_request_scheduler.sv
// Latches floor calls from single-cycle button pulses and runs a SCAN sweep
// that chooses the next target floor for the car controller.
module floor_request_scheduler #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] req_pulse,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                serve_pulse,
    output logic [N_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]  target_floor,
    output logic                target_valid,
    output logic [1:0]          dir
);

    localparam int unsigned NF = N_FLOORS;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [N_FLOORS-1:0]   pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  valid_q, valid_d;

    int unsigned           cur_u;
    logic                  in_range;
    logic                  above, below, here;
    logic [FLOOR_W-1:0]    lo_above, hi_below;

    always_comb begin
        cur_u    = 32'(cur_floor);
        in_range = (cur_u < NF);
    end

    // Serve clears a call and beats a same-cycle request for that floor.
    always_comb begin
        pending_d = pending_q;
        for (int unsigned i = 0; i < NF; i++) begin
            if (serve_pulse && in_range && (cur_u == i))
                pending_d[i] = 1'b0;
            else if (req_pulse[i])
                pending_d[i] = 1'b1;
        end
    end

    // Ascending scan: first hit above is the lowest, last hit below is the highest.
    always_comb begin
        above    = 1'b0;
        below    = 1'b0;
        here     = 1'b0;
        lo_above = '0;
        hi_below = '0;
        for (int unsigned i = 0; i < NF; i++) begin
            if (pending_q[i]) begin
                if ((i > cur_u) && !above) begin
                    above    = 1'b1;
                    lo_above = FLOOR_W'(i);
                end
                if (i < cur_u) begin
                    below    = 1'b1;
                    hi_below = FLOOR_W'(i);
                end
                if (i == cur_u)
                    here = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        valid_d  = valid_q;
        if (in_range) begin
            unique case (state_q)
                S_IDLE: begin
                    if (here) begin
                        target_d = cur_floor;
                        valid_d  = 1'b1;
                    end else if (above) begin
                        state_d  = S_UP;
                        target_d = lo_above;
                        valid_d  = 1'b1;
                    end else if (below) begin
                        state_d  = S_DOWN;
                        target_d = hi_below;
                        valid_d  = 1'b1;
                    end else begin
                        valid_d  = 1'b0;
                    end
                end
                S_UP: begin
                    if (here || above) begin
                        target_d = here ? cur_floor : lo_above;
                        valid_d  = 1'b1;
                    end else if (below) begin
                        state_d  = S_DOWN;
                        target_d = hi_below;
                        valid_d  = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        valid_d  = 1'b0;
                    end
                end
                S_DOWN: begin
                    if (here || below) begin
                        target_d = here ? cur_floor : hi_below;
                        valid_d  = 1'b1;
                    end else if (above) begin
                        state_d  = S_UP;
                        target_d = lo_above;
                        valid_d  = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        valid_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            target_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            valid_q   <= valid_d;
        end
    end

    assign pending      = pending_q;
    assign target_floor = target_q;
    assign target_valid = valid_q;
    assign dir          = state_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler: a per-cycle reference model of the
// SCAN rules plus literal expectations, and a 3-floor instance for out-of-range floors.
module tb_floor_request_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req_pulse;
    logic [1:0] cur_floor;
    logic       serve_pulse;
    logic [3:0] pending;
    logic [1:0] target_floor;
    logic       target_valid;
    logic [1:0] dir;

    logic [2:0] req2;
    logic [1:0] cur2;
    logic       serve2;
    logic [2:0] pend2;
    logic [1:0] tgt2;
    logic       val2;
    logic [1:0] dir2;

    int checks   = 0;
    int failures = 0;

    floor_request_scheduler #(.N_FLOORS(4), .FLOOR_W(2)) dut (
        .clk(clk), .rst(rst), .req_pulse(req_pulse), .cur_floor(cur_floor),
        .serve_pulse(serve_pulse), .pending(pending), .target_floor(target_floor),
        .target_valid(target_valid), .dir(dir)
    );

    floor_request_scheduler #(.N_FLOORS(3), .FLOOR_W(2)) dut3 (
        .clk(clk), .rst(rst), .req_pulse(req2), .cur_floor(cur2),
        .serve_pulse(serve2), .pending(pend2), .target_floor(tgt2),
        .target_valid(val2), .dir(dir2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 up, 2 down.
    logic [3:0] m_pend;
    int         m_state;
    int         m_tgt;
    bit         m_val;

    always @(posedge clk or negedge rst) begin
        int c, lo_up, hi_dn;
        bit here;
        if (!rst) begin
            m_pend  = '0;
            m_state = 0;
            m_tgt   = 0;
            m_val   = 1'b0;
        end else begin
            c = int'(cur_floor);
            if (c < 4) begin
                lo_up = -1;
                hi_dn = -1;
                here  = m_pend[c];
                for (int f = 3; f >= 0; f--)
                    if (m_pend[f] && f > c) lo_up = f;
                for (int f = 0; f < 4; f++)
                    if (m_pend[f] && f < c) hi_dn = f;
                if (m_state == 0 && here) begin
                    m_tgt = c; m_val = 1'b1;
                end else if (m_state == 1 && (here || lo_up >= 0)) begin
                    m_tgt = here ? c : lo_up; m_val = 1'b1;
                end else if (m_state == 2 && (here || hi_dn >= 0)) begin
                    m_tgt = here ? c : hi_dn; m_val = 1'b1;
                end else if (m_state != 1 && lo_up >= 0) begin
                    m_state = 1; m_tgt = lo_up; m_val = 1'b1;
                end else if (m_state != 2 && hi_dn >= 0) begin
                    m_state = 2; m_tgt = hi_dn; m_val = 1'b1;
                end else if (m_state == 2 && lo_up >= 0) begin
                    m_state = 1; m_tgt = lo_up; m_val = 1'b1;
                end else if (m_state == 1 && hi_dn >= 0) begin
                    m_state = 2; m_tgt = hi_dn; m_val = 1'b1;
                end else begin
                    m_state = 0; m_val = 1'b0;
                end
            end
            for (int f = 0; f < 4; f++) begin
                if (serve_pulse && c == f) m_pend[f] = 1'b0;
                else if (req_pulse[f])     m_pend[f] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("model_pending", 32'(pending), 32'(m_pend));
        check("model_dir", 32'(dir), 32'(m_state));
        check("model_valid", 32'(target_valid), 32'(m_val));
        check("model_target", 32'(target_floor), 32'(m_tgt));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; req_pulse = '0; cur_floor = '0; serve_pulse = 1'b0;
        req2 = '0; cur2 = '0; serve2 = 1'b0;
        repeat (2) tick();
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_dir", 32'(dir), 32'h0);
        check("rst_valid", 32'(target_valid), 32'h0);
        check("rst_target", 32'(target_floor), 32'h0);
        rst = 1'b1;

        // Mid-sweep asynchronous reset
        cur_floor = 2'd0; req_pulse = 4'b1010;
        tick(); req_pulse = '0;
        check("t1_pending_set", 32'(pending), 32'hA);
        tick();
        check("t1_dir_up", 32'(dir), 32'h1);
        check("t1_target", 32'(target_floor), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("t1_async_pending", 32'(pending), 32'h0);
        check("t1_async_dir", 32'(dir), 32'h0);
        check("t1_async_valid", 32'(target_valid), 32'h0);
        req_pulse = 4'b1111;
        tick();
        check("t1_held_pending", 32'(pending), 32'h0);
        check("t1_held_dir", 32'(dir), 32'h0);
        req_pulse = '0; rst = 1'b1;

        // Latch and latency
        cur_floor = 2'd0; req_pulse = 4'b0100;
        tick(); req_pulse = '0;
        check("t2_pending", 32'(pending), 32'h4);
        check("t2_dir_pre", 32'(dir), 32'h0);
        tick();
        check("t2_dir", 32'(dir), 32'h1);
        check("t2_target", 32'(target_floor), 32'h2);
        check("t2_valid", 32'(target_valid), 32'h1);
        cur_floor = 2'd2; serve_pulse = 1'b1;
        tick(); serve_pulse = 1'b0;
        check("t2_served", 32'(pending), 32'h0);
        tick();
        check("t2_idle", 32'(dir), 32'h0);

        // Sweep order
        cur_floor = 2'd1; req_pulse = 4'b1001;
        tick(); req_pulse = '0;
        tick();
        check("t3_dir_up", 32'(dir), 32'h1);
        check("t3_target3", 32'(target_floor), 32'h3);
        cur_floor = 2'd3; serve_pulse = 1'b1;
        tick(); serve_pulse = 1'b0;
        check("t3_pending_0001", 32'(pending), 32'h1);
        tick();
        check("t3_dir_down", 32'(dir), 32'h2);
        check("t3_target0", 32'(target_floor), 32'h0);
        cur_floor = 2'd0; serve_pulse = 1'b1;
        tick(); serve_pulse = 1'b0;
        check("t3_pending_0", 32'(pending), 32'h0);
        tick();
        check("t3_dir_idle", 32'(dir), 32'h0);
        check("t3_valid0", 32'(target_valid), 32'h0);

        // Clear wins over same-cycle request
        cur_floor = 2'd2; serve_pulse = 1'b1; req_pulse = 4'b0100;
        tick();
        check("t4_clear_wins", 32'(pending), 32'h0);
        req_pulse = 4'b0110;
        tick(); serve_pulse = 1'b0; req_pulse = '0;
        check("t4_mixed", 32'(pending), 32'h2);
        tick();

        // Call at current floor while idle
        rst = 1'b0;
        tick(); rst = 1'b1;
        cur_floor = 2'd1; req_pulse = 4'b0010;
        tick(); req_pulse = '0;
        check("t5_pending", 32'(pending), 32'h2);
        tick();
        check("t5_dir", 32'(dir), 32'h0);
        check("t5_target", 32'(target_floor), 32'h1);
        check("t5_valid", 32'(target_valid), 32'h1);

        // Out-of-range floor on the 3-floor instance
        rst = 1'b0;
        tick(); rst = 1'b1;
        cur2 = 2'd0; req2 = 3'b110;
        tick(); req2 = '0;
        check("t6_pending_110", 32'(pend2), 32'h6);
        tick();
        check("t6_dir_up", 32'(dir2), 32'h1);
        check("t6_target1", 32'(tgt2), 32'h1);
        cur2 = 2'd3; req2 = 3'b001;
        tick(); req2 = '0;
        check("t6_latch_oor", 32'(pend2), 32'h7);
        serve2 = 1'b1;
        tick(); serve2 = 1'b0;
        check("t6_serve_oor", 32'(pend2), 32'h7);
        check("t6_frozen_dir", 32'(dir2), 32'h1);
        check("t6_frozen_target", 32'(tgt2), 32'h1);
        check("t6_frozen_valid", 32'(val2), 32'h1);
        tick();
        check("t6_frozen_dir2", 32'(dir2), 32'h1);
        check("t6_frozen_target2", 32'(tgt2), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
